// File: rtl/mac_bist_pkg.sv
// mac_bist_pkg
// Shared definitions for the MAC BIST controller: the Galois feedback
// polynomial, the substitute seed used when a zero seed is requested,
// the controller state encoding and the single-step Galois shift helper.
package mac_bist_pkg;

    // x^32 + x^22 + x^2 + x + 1, Galois (right-shifting) form
    localparam logic [31:0] POLY         = 32'h8020_0003;
    // An all-zero LFSR would lock up, so a zero seed is replaced by this
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } bist_state_e;

    // One Galois step: shift right, fold the polynomial back in when the
    // bit shifted out was 1.
    function automatic logic [31:0] galois_shift(input logic [31:0] s);
        logic [31:0] fb;
        fb = s[0] ? POLY : 32'h0000_0000;
        return {1'b0, s[31:1]} ^ fb;
    endfunction

endpackage

// File: rtl/mac_bist_ctrl_if.sv
// mac_bist_ctrl_if
// Operand/result bus between the BIST controller and the MAC it tests.
//   mac_in_a   : operand a            (controller -> MAC)
//   mac_in_w   : operand w            (controller -> MAC)
//   mac_in_p   : partial-sum operand  (controller -> MAC)
//   vec_valid  : a test vector is on the bus this cycle
//   mac_result : a*w + p, combinational from mac_in_* (MAC -> controller)
// master = controller side, slave = MAC side.
interface mac_bist_ctrl_if #(
    parameter int A_WIDTH = 8,
    parameter int W_WIDTH = 8,
    parameter int P_WIDTH = 32
);
    logic [A_WIDTH-1:0] mac_in_a;
    logic [W_WIDTH-1:0] mac_in_w;
    logic [P_WIDTH-1:0] mac_in_p;
    logic               vec_valid;
    logic [P_WIDTH-1:0] mac_result;

    modport master (
        output mac_in_a,
        output mac_in_w,
        output mac_in_p,
        output vec_valid,
        input  mac_result
    );

    modport slave (
        input  mac_in_a,
        input  mac_in_w,
        input  mac_in_p,
        input  vec_valid,
        output mac_result
    );
endinterface

// File: rtl/bist_lfsr32.sv
// bist_lfsr32
// 32-bit Galois shift register used both as a pattern generator
// (data_in tied to zero) and as a multiple-input signature register.
//   clk, rst : clock, asynchronous active-high reset (register -> 0)
//   load     : load load_val (wins over step)
//   load_val : value loaded on load
//   step     : advance one Galois step and XOR in data_in
//   data_in  : parallel data folded in on each step
//   q        : current register contents
module bist_lfsr32
    import mac_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    input  logic [31:0] data_in,
    output logic [31:0] q
);

    logic [31:0] reg_d;
    logic [31:0] reg_q;

    // Next-value selection: load, step with data fold-in, or hold
    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = load_val;
        end else if (step) begin
            reg_d = galois_shift(reg_q) ^ data_in;
        end else begin
            reg_d = reg_q;
        end
    end

    // Register with asynchronous reset to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q <= 32'h0000_0000;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/mac_bist_ctrl.sv
// mac_bist_ctrl
// BIST controller for one combinational signed MAC (a*w + p). On start it
// seeds an LFSR, drives NUM_PATTERNS pseudo-random vectors (one per cycle)
// straight from the LFSR bits, folds every MAC result into a MISR and
// finally compares the MISR against expected_sig.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : run request, honoured only in IDLE or DONE
//   abort        : back to IDLE from anywhere, done stays low
//   seed         : LFSR seed latched on start (0 replaced by DEFAULT_SEED)
//   expected_sig : golden signature, sampled in COMPARE
//   mac_bus      : operand/result bus to the MAC (master side)
//   busy         : high in RUN and COMPARE
//   done         : high in DONE
//   pass         : signature matched (meaningful while done)
//   signature    : current MISR value
module mac_bist_ctrl
    import mac_bist_pkg::*;
#(
    parameter int A_WIDTH      = 8,
    parameter int W_WIDTH      = 8,
    parameter int P_WIDTH      = 32,
    parameter int NUM_PATTERNS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             seed,
    input  logic [31:0]             expected_sig,
    mac_bist_ctrl_if.master         mac_bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [31:0]             signature
);

    localparam int                 CNT_W    = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NUM_PATTERNS - 1);

    bist_state_e      state_d,     state_q;
    logic [CNT_W-1:0] count_d,     count_q;
    logic             pass_d,      pass_q;
    logic             busy_d,      busy_q;
    logic             done_d,      done_q;
    logic             vec_valid_d, vec_valid_q;

    logic        run_load_s;
    logic        run_step_s;
    logic [31:0] seed_eff_s;
    logic [31:0] lfsr_s;
    logic [31:0] misr_s;
    logic [31:0] rot_s;
    logic [31:0] mac_sext_s;

    assign seed_eff_s = (seed == 32'h0000_0000) ? DEFAULT_SEED : seed;
    // Sign-extend the MAC result so negative sums fold in full-width
    assign mac_sext_s = 32'(signed'(mac_bus.mac_result));

    bist_lfsr32 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (run_load_s),
        .load_val (seed_eff_s),
        .step     (run_step_s),
        .data_in  (32'h0000_0000),
        .q        (lfsr_s)
    );

    bist_lfsr32 u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (run_load_s),
        .load_val (32'h0000_0000),
        .step     (run_step_s),
        .data_in  (mac_sext_s),
        .q        (misr_s)
    );

    // Operands are plain slices of the LFSR register so the LFSR -> MAC ->
    // MISR path has no extra logic in front of the MAC.
    assign rot_s            = {lfsr_s[15:0], lfsr_s[31:16]};
    assign mac_bus.mac_in_a = lfsr_s[A_WIDTH-1:0];
    assign mac_bus.mac_in_w = lfsr_s[A_WIDTH+W_WIDTH-1:A_WIDTH];
    assign mac_bus.mac_in_p = rot_s[P_WIDTH-1:0];

    // Next-state, counter, pass and register-control decode; abort overrides all
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pass_d     = pass_q;
        run_load_s = 1'b0;
        run_step_s = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = CNT_ZERO;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        run_load_s = 1'b1;
                        count_d    = CNT_ZERO;
                        pass_d     = 1'b0;
                        state_d    = RUN;
                    end else begin
                        state_d    = state_q;
                    end
                end
                RUN: begin
                    // The vector on the bus this cycle is absorbed at this edge
                    run_step_s = 1'b1;
                    count_d    = count_q + CNT_ONE;
                    if (count_q == CNT_LAST) begin
                        state_d = COMPARE;
                    end else begin
                        state_d = RUN;
                    end
                end
                COMPARE: begin
                    pass_d  = (misr_s == expected_sig);
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it
    always_comb begin
        busy_d      = (state_d == RUN) || (state_d == COMPARE);
        done_d      = (state_d == DONE);
        vec_valid_d = (state_d == RUN);
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= CNT_ZERO;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign mac_bus.vec_valid = vec_valid_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign signature         = misr_s;

endmodule

// File: tb/tb_mac_bist_ctrl.sv
// tb_mac_bist_ctrl
// Two controllers (NUM_PATTERNS = 1 and 256), each driving its own
// behavioural MAC. Expected signatures come from a plain software model
// of the pattern generator and signature compactor.
module tb_mac_bist_ctrl;

    localparam logic [31:0] M_POLY = 32'h8020_0003;

    logic clk;
    logic rst;
    logic stuck0;

    logic [1:0]  start_v;
    logic [1:0]  abort_v;
    logic [31:0] seed_v [2];
    logic [31:0] exp_v  [2];
    wire  [1:0]  busy_v;
    wire  [1:0]  done_v;
    wire  [1:0]  pass_v;
    wire  [1:0][31:0] sig_v;

    int checks_cnt;
    int fail_cnt;

    mac_bist_ctrl_if #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32)) bus0 ();
    mac_bist_ctrl_if #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32)) bus1 ();

    function automatic logic [31:0] mac_fn(input logic [7:0] a, input logic [7:0] w,
                                           input logic [31:0] p);
        int ai;
        int wi;
        ai = $signed(a);
        wi = $signed(w);
        return 32'(ai * wi) + p;
    endfunction

    assign bus0.mac_result = mac_fn(bus0.mac_in_a, bus0.mac_in_w, bus0.mac_in_p);
    assign bus1.mac_result = mac_fn(bus1.mac_in_a, bus1.mac_in_w, bus1.mac_in_p)
                             & ~{31'd0, stuck0};

    mac_bist_ctrl #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32), .NUM_PATTERNS(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .seed(seed_v[0]), .expected_sig(exp_v[0]), .mac_bus(bus0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]));

    mac_bist_ctrl #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32), .NUM_PATTERNS(256)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .seed(seed_v[1]), .expected_sig(exp_v[1]), .mac_bus(bus1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .signature(sig_v[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gstep(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? M_POLY : 32'd0);
    endfunction

    // Signature after n vectors from the given seed (MISR starts at 0)
    function automatic logic [31:0] ref_sig(input logic [31:0] sd, input int n, input logic stuck);
        logic [31:0] s;
        logic [31:0] m;
        logic [31:0] r;
        s = (sd == 32'd0) ? 32'd1 : sd;
        m = 32'd0;
        for (int k = 0; k < n; k++) begin
            r = mac_fn(s[7:0], s[15:8], {s[15:0], s[31:16]});
            if (stuck) r[0] = 1'b0;
            m = gstep(m) ^ r;
            s = gstep(s);
        end
        return m;
    endfunction

    // Start a run and follow it until done, abort point or cycle budget
    task automatic do_run(input int inst, input logic [31:0] sd, input logic [31:0] exp_sig,
                          input int abort_at, input int restart_at,
                          output int cycles, output int vcount, output logic done_seen);
        logic [31:0] s0;
        s0 = (sd == 32'd0) ? 32'd1 : sd;
        @(negedge clk);
        seed_v[inst]  = sd;
        exp_v[inst]   = exp_sig;
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        cycles = 0;
        vcount = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cycles++;
            if ((inst == 0) ? bus0.vec_valid : bus1.vec_valid) vcount++;
            if (cycles == 1) begin
                check_eq("vec0_a", (inst == 0) ? bus0.mac_in_a : bus1.mac_in_a, s0[7:0]);
                check_eq("vec0_w", (inst == 0) ? bus0.mac_in_w : bus1.mac_in_w, s0[15:8]);
                check_eq("vec0_p", (inst == 0) ? bus0.mac_in_p : bus1.mac_in_p,
                         {s0[15:0], s0[31:16]});
                check_eq("busy_run", busy_v[inst], 1'b1);
            end
            if (done_v[inst]) begin
                done_seen = 1'b1;
                break;
            end
            if (abort_at >= 0 && vcount == abort_at + 1) begin
                abort_v[inst] = 1'b1;
                @(negedge clk);
                abort_v[inst] = 1'b0;
                break;
            end
            start_v[inst] = (cycles == restart_at);
            if (cycles == restart_at) seed_v[inst] = sd ^ 32'hDEAD_BEEF;
            @(negedge clk);
            start_v[inst] = 1'b0;
        end
    endtask

    task automatic full_run(input int inst, input logic [31:0] sd, input logic [31:0] exp_sig,
                            input int restart_at, input logic stuck, input string tag);
        int np;
        int cyc;
        int vc;
        logic dn;
        logic [31:0] golden;
        np = (inst == 0) ? 1 : 256;
        golden = ref_sig(sd, np, stuck);
        do_run(inst, sd, exp_sig, -1, restart_at, cyc, vc, dn);
        check_eq({tag, "_done"}, dn, 1'b1);
        check_eq({tag, "_cycles"}, cyc, np + 2);
        check_eq({tag, "_vvalid"}, vc, np);
        check_eq({tag, "_sig"}, sig_v[inst], golden);
        check_eq({tag, "_pass"}, pass_v[inst], golden == exp_sig);
        check_eq({tag, "_busy"}, busy_v[inst], 1'b0);
        repeat (2) @(negedge clk);
        check_eq({tag, "_hold_done"}, done_v[inst], 1'b1);
        check_eq({tag, "_hold_sig"}, sig_v[inst], golden);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy_v, 2'b00);
        check_eq({tag, "_done"}, done_v, 2'b00);
        check_eq({tag, "_pass"}, pass_v, 2'b00);
        check_eq({tag, "_sig0"}, sig_v[0], 32'd0);
        check_eq({tag, "_sig1"}, sig_v[1], 32'd0);
        check_eq({tag, "_vv"}, {bus1.vec_valid, bus0.vec_valid}, 2'b00);
        check_eq({tag, "_a"}, bus1.mac_in_a, 8'd0);
        check_eq({tag, "_w"}, bus1.mac_in_w, 8'd0);
        check_eq({tag, "_p"}, bus1.mac_in_p, 32'd0);
        check_eq({tag, "_p0"}, bus0.mac_in_p, 32'd0);
    endtask

    initial begin
        logic [31:0] sd;
        logic [31:0] golden;
        logic [31:0] first_sig;
        int cyc;
        int vc;
        logic dn;

        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        stuck0     = 1'b0;
        start_v    = 2'b00;
        abort_v    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            seed_v[i] = 32'd0;
            exp_v[i]  = 32'd0;
        end
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single-pattern runs with known answer
        full_run(0, 32'd1, 32'h0001_0000, -1, 1'b0, "np1_pass");
        check_eq("np1_known_sig", sig_v[0], 32'h0001_0000);
        full_run(0, 32'd1, 32'h0001_0001, -1, 1'b0, "np1_fail");
        check_eq("np1_fail_known_sig", sig_v[0], 32'h0001_0000);
        full_run(0, 32'd0, 32'h0001_0000, -1, 1'b0, "np1_seed0");
        check_eq("np1_seed0_known_sig", sig_v[0], 32'h0001_0000);

        // Fixed seed, two back-to-back runs
        sd = 32'h1234_5678;
        golden = ref_sig(sd, 256, 1'b0);
        full_run(1, sd, golden, -1, 1'b0, "fixed_a");
        first_sig = sig_v[1];
        full_run(1, sd, golden, -1, 1'b0, "fixed_b");
        check_eq("fixed_repeat", sig_v[1], first_sig);

        // Random seeds, randomly matching or corrupted golden values
        for (int n = 0; n < 3; n++) begin
            sd = $urandom;
            golden = ref_sig(sd, 256, 1'b0);
            if ($urandom_range(0, 1) == 0) golden = golden ^ (32'd1 << $urandom_range(0, 31));
            full_run(1, sd, golden, -1, 1'b0, "rand");
        end

        // Stuck-at-0 on result bit 0 against a clean golden signature
        sd = 32'hCAFE_0042;
        stuck0 = 1'b1;
        full_run(1, sd, ref_sig(sd, 256, 1'b0), -1, 1'b1, "stuck");
        check_eq("stuck_detect", pass_v[1], 1'b0);
        stuck0 = 1'b0;

        // Abort while vector 100 is on the bus
        sd = 32'h0BAD_F00D;
        do_run(1, sd, 32'd0, 100, -1, cyc, vc, dn);
        check_eq("abort_no_done_seen", dn, 1'b0);
        check_eq("abort_vv", bus1.vec_valid, 1'b0);
        check_eq("abort_busy", busy_v[1], 1'b0);
        check_eq("abort_done", done_v[1], 1'b0);
        check_eq("abort_sig", sig_v[1], ref_sig(sd, 100, 1'b0));
        repeat (3) @(negedge clk);
        check_eq("abort_done_later", done_v[1], 1'b0);
        check_eq("abort_sig_hold", sig_v[1], ref_sig(sd, 100, 1'b0));

        // Start pulse mid-run is ignored
        sd = 32'h5555_AAAA;
        full_run(1, sd, ref_sig(sd, 256, 1'b0), 50, 1'b0, "start_in_run");

        // Start from DONE with a new seed: MISR must restart from zero
        sd = 32'h7777_0001;
        full_run(1, sd, ref_sig(sd, 256, 1'b0), -1, 1'b0, "restart_done");

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        seed_v[1]  = 32'h3141_5926;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;

        sd = 32'h2468_ACE0;
        full_run(1, sd, ref_sig(sd, 256, 1'b0), -1, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
